// File: rtl/anc_sample_fifo_if.sv
// Handshake bundle for the ANC sample FIFO: producer push side, consumer pop side and status.
interface anc_sample_fifo_if #(
    parameter int unsigned DW    = 16,
    parameter int unsigned NCH   = 4,
    parameter int unsigned DEPTH = 4
) ();
    logic                       in_valid;
    logic [NCH*DW-1:0]          in_data;
    logic                       in_ready;
    logic                       out_valid;
    logic [NCH*DW-1:0]          out_data;
    logic                       out_ready;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic                       overflow;
    logic                       ovf_clr;

    modport master (
        output in_valid, in_data, out_ready, ovf_clr,
        input  in_ready, out_valid, out_data, level, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready, ovf_clr,
        output in_ready, out_valid, out_data, level, overflow
    );
endinterface

// File: rtl/anc_sample_fifo.sv
// Multi-channel input sample FIFO with valid/ready on both sides, a selectable
// full-policy (drop newest / overwrite oldest) and a sticky overflow flag.
module anc_sample_fifo #(
    parameter int unsigned DW       = 16,
    parameter int unsigned NCH      = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned OVF_MODE = 0
) (
    input logic              clk,
    input logic              rst_n,
    anc_sample_fifo_if.slave bus
);
    localparam int unsigned W    = NCH * DW;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            ovf_q, ovf_d;

    logic full, empty, in_ready, push, pop, overwrite, drop;

    assign full      = (level_q == LvlW'(DEPTH));
    assign empty     = (level_q == '0);
    assign in_ready  = (OVF_MODE != 0) ? 1'b1 : !full;
    assign push      = bus.in_valid && in_ready;
    assign pop       = !empty && bus.out_ready;
    // Full with no pop in overwrite mode: the write lands on the oldest slot,
    // so the read pointer must skip past it.
    assign overwrite = (OVF_MODE != 0) && full && push && !pop;
    assign drop      = (OVF_MODE == 0) && full && bus.in_valid;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop || overwrite) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop && !overwrite) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        if (drop || overwrite) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.level     = level_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_anc_sample_fifo.sv
// Bench for anc_sample_fifo: one instance per overflow policy, checked every cycle
// against a queue-based model plus directed literal expectations.
module tb_anc_sample_fifo;
    localparam int unsigned DW    = 16;
    localparam int unsigned NCH   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = NCH * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    anc_sample_fifo_if #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) bus0 ();
    anc_sample_fifo_if #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) bus1 ();

    anc_sample_fifo #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .OVF_MODE(0)) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );
    anc_sample_fifo #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .OVF_MODE(1)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each FIFO is just an ordered list of words.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic m_ovf0 = 1'b0;
    logic m_ovf1 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_ovf0 = 1'b0;
            m_ovf1 = 1'b0;
        end else begin
            logic full0, pop0, set0, pop1, set1;
            full0 = (q0.size() == DEPTH);
            pop0  = (q0.size() != 0) && bus0.out_ready;
            set0  = bus0.in_valid && full0;
            if (pop0) void'(q0.pop_front());
            if (bus0.in_valid && !full0) q0.push_back(bus0.in_data);
            m_ovf0 = set0 ? 1'b1 : (bus0.ovf_clr ? 1'b0 : m_ovf0);

            pop1 = (q1.size() != 0) && bus1.out_ready;
            set1 = 1'b0;
            if (pop1) void'(q1.pop_front());
            if (bus1.in_valid) begin
                if (q1.size() == DEPTH) begin
                    void'(q1.pop_front());
                    set1 = 1'b1;
                end
                q1.push_back(bus1.in_data);
            end
            m_ovf1 = set1 ? 1'b1 : (bus1.ovf_clr ? 1'b0 : m_ovf1);

            #1;
            if (rst_n) begin
                chk("m0_level", 64'(bus0.level), 64'(q0.size()));
                chk("m0_out_valid", 64'(bus0.out_valid), 64'(q0.size() != 0));
                chk("m0_overflow", 64'(bus0.overflow), 64'(m_ovf0));
                chk("m0_in_ready", 64'(bus0.in_ready), 64'(q0.size() != DEPTH));
                if (q0.size() != 0) chk("m0_out_data", bus0.out_data, q0[0]);
                chk("m1_level", 64'(bus1.level), 64'(q1.size()));
                chk("m1_out_valid", 64'(bus1.out_valid), 64'(q1.size() != 0));
                chk("m1_overflow", 64'(bus1.overflow), 64'(m_ovf1));
                chk("m1_in_ready", 64'(bus1.in_ready), 64'd1);
                if (q1.size() != 0) chk("m1_out_data", bus1.out_data, q1[0]);
            end
        end
    end

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                         input logic clr);
        bus0.in_valid  = iv;
        bus0.in_data   = d;
        bus0.out_ready = ordy;
        bus0.ovf_clr   = clr;
        bus1.in_valid  = iv;
        bus1.in_data   = d;
        bus1.out_ready = ordy;
        bus1.ovf_clr   = clr;
    endtask

    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                        input logic clr);
        drive(iv, d, ordy, clr);
        @(negedge clk);
    endtask

    logic [W-1:0] words[6];
    logic [W-1:0] exp0[4];
    logic [W-1:0] exp1[4];

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) words[i] = {4{16'(16'hA000 + i)}};
        exp0 = '{words[0], words[1], words[2], words[3]};
        exp1 = '{words[2], words[3], words[4], words[5]};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid0", 64'(bus0.out_valid), 64'd0);
        chk("rst_level0", 64'(bus0.level), 64'd0);
        chk("rst_overflow0", 64'(bus0.overflow), 64'd0);
        chk("rst_out_data0", bus0.out_data, 64'd0);
        chk("rst_in_ready0", 64'(bus0.in_ready), 64'd1);
        chk("rst_out_data1", bus1.out_data, 64'd0);

        // Single push, one-cycle latency, then pop.
        step(1'b1, 64'h0001_0002_0003_0004, 1'b0, 1'b0);
        chk("push1_valid", 64'(bus0.out_valid), 64'd1);
        chk("push1_level", 64'(bus0.level), 64'd1);
        chk("push1_data", bus0.out_data, 64'h0001_0002_0003_0004);
        chk("model_push1", 64'(q0.size()), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("pop1_level", 64'(bus0.level), 64'd0);
        chk("pop1_valid", 64'(bus0.out_valid), 64'd0);

        // No fall-through: push into empty with out_ready high stays stored.
        step(1'b1, 64'h1234, 1'b1, 1'b0);
        chk("nofall_level", 64'(bus0.level), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Fill past full: A..F.
        for (int i = 0; i < 6; i++) begin
            if (i == 4) chk("full_in_ready0", 64'(bus0.in_ready), 64'd0);
            step(1'b1, words[i], 1'b0, 1'b0);
        end
        chk("ovf0_set", 64'(bus0.overflow), 64'd1);
        chk("ovf1_set", 64'(bus1.overflow), 64'd1);
        chk("ovf1_level", 64'(bus1.level), 64'd4);
        chk("model_ovf1", 64'(m_ovf1), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain0", bus0.out_data, exp0[i]);
            chk("drain1", bus1.out_data, exp1[i]);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drained_level0", 64'(bus0.level), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr0", 64'(bus0.overflow), 64'd0);
        chk("ovf_clr1", 64'(bus1.overflow), 64'd0);

        // Continuous push+pop across several pointer wraps.
        step(1'b1, 64'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 3 * DEPTH; i++) begin
            step(1'b1, 64'(i), 1'b1, 1'b0);
            chk("stream_level0", 64'(bus0.level), 64'd1);
            chk("stream_data0", bus0.out_data, 64'(i));
        end
        chk("stream_ovf0", 64'(bus0.overflow), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Overflow set wins over a simultaneous clear; then async reset at level 3.
        for (int i = 0; i < DEPTH; i++) step(1'b1, words[i], 1'b0, 1'b0);
        step(1'b1, words[5], 1'b0, 1'b1);
        chk("ovf_prio0", 64'(bus0.overflow), 64'd1);
        chk("ovf_prio1", 64'(bus1.overflow), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_level0", 64'(bus0.level), 64'd3);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_level0", 64'(bus0.level), 64'd0);
        chk("async_rst_valid0", 64'(bus0.out_valid), 64'd0);
        chk("async_rst_level1", 64'(bus1.level), 64'd0);
        chk("async_rst_ovf0", 64'(bus0.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), {$urandom, $urandom},
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
